// File: rtl/text_string_renderer_pkg.sv
// Shared geometry, glyph code set and 16x16 font lookup for the text string renderer.
// The font is stored as 8x8 bitmaps and each bitmap pixel is doubled on both axes.
package text_string_renderer_pkg;

  localparam int VGA_W       = 11;
  localparam int FONT_W      = 16;
  localparam int FONT_H      = 16;
  localparam int FONT_CODE_W = 4;
  localparam int FONT_BLANK  = 15;

  typedef logic [VGA_W-1:0] vga_coord_t;

  typedef enum logic [FONT_CODE_W-1:0] {
    GL_0     = 4'd0,
    GL_1     = 4'd1,
    GL_2     = 4'd2,
    GL_3     = 4'd3,
    GL_4     = 4'd4,
    GL_5     = 4'd5,
    GL_6     = 4'd6,
    GL_7     = 4'd7,
    GL_8     = 4'd8,
    GL_9     = 4'd9,
    GL_A     = 4'd10,
    GL_E     = 4'd11,
    GL_G     = 4'd12,
    GL_M     = 4'd13,
    GL_O     = 4'd14,
    GL_BLANK = 4'd15
  } glyph_code_e;

  // Top byte is the top row; bit 7 of each byte is the leftmost pixel.
  function automatic logic [63:0] font8(input logic [FONT_CODE_W-1:0] code);
    case (code)
      GL_0:    font8 = 64'h3C66_6E76_6666_3C00;
      GL_1:    font8 = 64'h1838_1818_1818_7E00;
      GL_2:    font8 = 64'h3C66_060C_3060_7E00;
      GL_3:    font8 = 64'h3C66_061C_0666_3C00;
      GL_4:    font8 = 64'h0C1C_3C6C_7E0C_0C00;
      GL_5:    font8 = 64'h7E60_7C06_0666_3C00;
      GL_6:    font8 = 64'h3C60_7C66_6666_3C00;
      GL_7:    font8 = 64'h7E06_0C18_3030_3000;
      GL_8:    font8 = 64'h3C66_663C_6666_3C00;
      GL_9:    font8 = 64'h3C66_663E_060C_3800;
      GL_A:    font8 = 64'h183C_6666_7E66_6600;
      GL_E:    font8 = 64'h7E60_607C_6060_7E00;
      GL_G:    font8 = 64'h3C66_606E_6666_3C00;
      GL_M:    font8 = 64'h6377_7F6B_6363_6300;
      GL_O:    font8 = 64'h3C66_6666_6666_3C00;
      default: font8 = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [FONT_W-1:0] glyph_row(input logic [FONT_CODE_W-1:0] code,
                                                  input logic [$clog2(FONT_H)-1:0] row);
    logic [63:0] bits;
    logic [2:0]  r8;
    logic [7:0]  line;
    bits = font8(code);
    r8   = 3'(row >> 1);
    line = bits[8*(3'd7 - r8) +: 8];
    for (int i = 0; i < FONT_W; i++) begin
      glyph_row[i] = line[i/2];
    end
  endfunction

endpackage

// File: rtl/text_string_renderer_if.sv
// Pixel-side and buffer-write signals of the text string renderer, grouped with driver/renderer views.
interface text_string_renderer_if
  import text_string_renderer_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int CODE_W    = FONT_CODE_W
);
  vga_coord_t                     iPosX;
  vga_coord_t                     iPosY;
  vga_coord_t                     iVGA_X;
  vga_coord_t                     iVGA_Y;
  logic [1:0]                     iScale;
  logic                           iEnable;
  logic                           iBlinkEn;
  logic                           iFrameTick;
  logic                           iWrEn;
  logic [$clog2(NUM_CHARS)-1:0]   iWrAddr;
  logic [CODE_W-1:0]              iWrData;
  logic                           oDrawText;

  modport master (
    output iPosX, iPosY, iVGA_X, iVGA_Y, iScale, iEnable, iBlinkEn, iFrameTick,
    output iWrEn, iWrAddr, iWrData,
    input  oDrawText
  );

  modport slave (
    input  iPosX, iPosY, iVGA_X, iVGA_Y, iScale, iEnable, iBlinkEn, iFrameTick,
    input  iWrEn, iWrAddr, iWrData,
    output oDrawText
  );
endinterface

// File: rtl/text_string_renderer_glyph_rom.sv
// Synchronous glyph ROM: the address is registered, row data is valid one cycle later.
module glyph_rom
  import text_string_renderer_pkg::*;
(
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic [FONT_CODE_W+$clog2(FONT_H)-1:0]   i_addr,
  output logic [FONT_W-1:0]                       o_q
);
  localparam int ROW_W = $clog2(FONT_H);

  logic [FONT_CODE_W+ROW_W-1:0] r_addr;

  // Address register of the ROM port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else begin
      r_addr <= i_addr;
    end
  end

  assign o_q = glyph_row(r_addr[ROW_W +: FONT_CODE_W], r_addr[ROW_W-1:0]);
endmodule

// File: rtl/text_string_renderer.sv
// Renders a buffered string of glyph codes at a scaled screen position.
// Two-stage pipeline: geometry + ROM address, then ROM bit select and gating.
module text_string_renderer
  import text_string_renderer_pkg::*;
#(
  parameter int NUM_CHARS    = 8,
  parameter int CODE_W       = FONT_CODE_W,
  parameter int GLYPH_W      = FONT_W,
  parameter int GLYPH_H      = FONT_H,
  parameter int BLANK_CODE   = FONT_BLANK,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  text_string_renderer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CHARS);
  localparam int COL_W = $clog2(GLYPH_W);
  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam vga_coord_t X_EXT = VGA_W'(NUM_CHARS * GLYPH_W);
  localparam vga_coord_t Y_EXT = VGA_W'(GLYPH_H);

  logic [CODE_W-1:0]       r_buf [NUM_CHARS];
  logic [CNT_W-1:0]        r_blink_cnt;
  logic                    r_phase;
  logic                    r_hit;
  logic                    r_blank;
  logic [COL_W-1:0]        r_col;
  logic                    r_draw;

  vga_coord_t              w_rel_x;
  vga_coord_t              w_rel_y;
  vga_coord_t              w_sx;
  vga_coord_t              w_sy;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_idx;
  logic [COL_W-1:0]        w_col;
  logic [ROW_W-1:0]        w_row;
  logic [CODE_W-1:0]       w_code;
  logic [GLYPH_W-1:0]      w_rom_q;
  logic [COL_W-1:0]        w_bit;

  // Stage 0 geometry; comparing the scaled offset equals comparing against the scaled extent.
  always_comb begin
    w_rel_x = bus.iVGA_X - bus.iPosX;
    w_rel_y = bus.iVGA_Y - bus.iPosY;
    w_sx    = w_rel_x >> bus.iScale;
    w_sy    = w_rel_y >> bus.iScale;
    if ((bus.iVGA_X >= bus.iPosX) && (bus.iVGA_Y >= bus.iPosY)) begin
      w_hit = (w_sx < X_EXT) && (w_sy < Y_EXT);
    end else begin
      w_hit = 1'b0;
    end
  end

  assign w_idx  = w_sx[COL_W +: IDX_W];
  assign w_col  = w_sx[COL_W-1:0];
  assign w_row  = w_sy[ROW_W-1:0];
  assign w_code = r_buf[w_idx];
  assign w_bit  = COL_W'(GLYPH_W - 1) - r_col;

  glyph_rom u_rom (
    .i_clk   (iClk),
    .i_rst_n (iRst_n),
    .i_addr  ({w_code, w_row}),
    .o_q     (w_rom_q)
  );

  // Character buffer; a same-cycle read of the written entry still sees the old code.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_buf[i] <= CODE_W'(BLANK_CODE);
      end
    end else if (bus.iWrEn) begin
      r_buf[bus.iWrAddr] <= bus.iWrData;
    end
  end

  // Blink divider; phase 1 hides the string when blinking is enabled.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (bus.iFrameTick) begin
      if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Pipeline registers: stage 0 side info, then the gated pixel bit.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_hit   <= 1'b0;
      r_blank <= 1'b0;
      r_col   <= '0;
      r_draw  <= 1'b0;
    end else begin
      r_hit   <= w_hit;
      r_blank <= (w_code == CODE_W'(BLANK_CODE));
      r_col   <= w_col;
      r_draw  <= r_hit & bus.iEnable & ~r_blank & ~(bus.iBlinkEn & r_phase) & w_rom_q[w_bit];
    end
  end

  assign bus.oDrawText = r_draw;
endmodule

// File: tb/tb_text_string_renderer.sv
// Self-checking bench: directed scenarios plus random traffic against a pixel-level reference model.
module tb_text_string_renderer;
  localparam int NUM = 8;
  localparam int GW  = 16;
  localparam int GH  = 16;
  localparam int BF  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  text_string_renderer_if #(.NUM_CHARS(NUM), .CODE_W(4)) bus ();

  text_string_renderer #(
    .NUM_CHARS(NUM), .CODE_W(4), .GLYPH_W(GW), .GLYPH_H(GH), .BLANK_CODE(15), .BLINK_FRAMES(BF)
  ) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // 8x8 reference bitmaps, row by row, bit 7 leftmost; each pixel is 2x2 on screen.
  logic [7:0] font [0:14][0:7] = '{
    '{8'h3C,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h3C,8'h00},
    '{8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h06,8'h0C,8'h30,8'h60,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h66,8'h3C,8'h00},
    '{8'h0C,8'h1C,8'h3C,8'h6C,8'h7E,8'h0C,8'h0C,8'h00},
    '{8'h7E,8'h60,8'h7C,8'h06,8'h06,8'h66,8'h3C,8'h00},
    '{8'h3C,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h3C,8'h00},
    '{8'h7E,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h00},
    '{8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h3C,8'h00},
    '{8'h3C,8'h66,8'h66,8'h3E,8'h06,8'h0C,8'h38,8'h00},
    '{8'h18,8'h3C,8'h66,8'h66,8'h7E,8'h66,8'h66,8'h00},
    '{8'h7E,8'h60,8'h60,8'h7C,8'h60,8'h60,8'h7E,8'h00},
    '{8'h3C,8'h66,8'h60,8'h6E,8'h66,8'h66,8'h3C,8'h00},
    '{8'h63,8'h77,8'h7F,8'h6B,8'h63,8'h63,8'h63,8'h00},
    '{8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00}
  };

  int shadow [NUM];
  int ticks   = 0;
  bit p0_prev = 1'b0;
  bit exp_out = 1'b0;

  function automatic bit geom(int vx, int vy, int px, int py, int s);
    int pix, rx, ry, ci, col, row, code;
    pix = 1 << s;
    if (vx < px || vy < py) return 1'b0;
    rx = vx - px;
    ry = vy - py;
    if (rx >= NUM * GW * pix || ry >= GH * pix) return 1'b0;
    ci   = rx / (GW * pix);
    col  = (rx / pix) % GW;
    row  = (ry / pix) % GH;
    code = shadow[ci];
    if (code == 15) return 1'b0;
    return font[code][row/2][7 - col/2];
  endfunction

  function automatic bit phase_hidden();
    return ((ticks / BF) % 2) == 1;
  endfunction

  function automatic bit model_pixel(int vx, int vy);
    return geom(vx, vy, int'(bus.iPosX), int'(bus.iPosY), int'(bus.iScale))
           & bus.iEnable & ~(bus.iBlinkEn & phase_hidden());
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model advances on each active edge; the DUT output is compared on the falling edge.
  initial begin
    for (int i = 0; i < NUM; i++) shadow[i] = 15;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        exp_out = p0_prev & bus.iEnable & ~(bus.iBlinkEn & phase_hidden());
        p0_prev = geom(int'(bus.iVGA_X), int'(bus.iVGA_Y), int'(bus.iPosX), int'(bus.iPosY),
                       int'(bus.iScale));
        if (bus.iWrEn) shadow[bus.iWrAddr] = int'(bus.iWrData);
        if (bus.iFrameTick) ticks++;
      end
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NUM; i++) shadow[i] = 15;
        ticks   = 0;
        p0_prev = 1'b0;
        exp_out = 1'b0;
      end
      chk("stream", int'(bus.oDrawText), int'(exp_out));
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.iWrEn      = 1'b0;
    bus.iFrameTick = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    bus.iWrEn   = 1'b1;
    bus.iWrAddr = 3'(a);
    bus.iWrData = 4'(d);
    step();
  endtask

  task automatic setpos(input int x, input int y, input int s);
    bus.iPosX  = 11'(x);
    bus.iPosY  = 11'(y);
    bus.iScale = 2'(s);
  endtask

  task automatic pin(input string name, input int x, input int y, input int exp);
    bus.iVGA_X = 11'(x);
    bus.iVGA_Y = 11'(y);
    step();
    step();
    chk(name, int'(bus.oDrawText), exp);
    chk({name, "_model"}, int'(model_pixel(x, y)), exp);
  endtask

  task automatic sweep(input int y0, input int y1, input int x0, input int x1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        bus.iVGA_X = 11'(x);
        bus.iVGA_Y = 11'(y);
        step();
      end
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic tick();
    bus.iFrameTick = 1'b1;
    step();
  endtask

  initial begin
    bus.iPosX = 11'd100; bus.iPosY = 11'd50; bus.iVGA_X = 11'd0; bus.iVGA_Y = 11'd0;
    bus.iScale = 2'd0; bus.iEnable = 1'b1; bus.iBlinkEn = 1'b0; bus.iFrameTick = 1'b0;
    bus.iWrEn = 1'b0; bus.iWrAddr = 3'd0; bus.iWrData = 4'd0;
    #2 rst_n = 1'b0;
    #1 chk("reset_out", int'(bus.oDrawText), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Basic draw at s=0
    for (int i = 0; i < NUM; i++) wr(i, i);
    setpos(100, 50, 0);
    sweep(50, 51, 99, 228);
    pin("g0_col0", 100, 50, 0);
    pin("g0_col4", 104, 50, 1);
    pin("g1_col6", 122, 50, 1);
    pin("g7_col2", 214, 50, 1);
    pin("left_edge", 99, 50, 0);
    pin("right_edge", 228, 50, 0);

    // Scaling by 4
    setpos(100, 50, 2);
    wr(0, 1);
    sweep(50, 53, 96, 615);
    pin("s2_corner", 103, 53, 0);
    pin("s2_col6", 124, 50, 1);
    pin("s2_col6_blk", 127, 53, 1);
    pin("s2_g7", 556, 50, 1);
    pin("s2_extent", 612, 50, 0);

    // Blank buffer after reset, then blanked entry
    do_reset();
    setpos(100, 50, 0);
    sweep(48, 52, 96, 232);
    pin("rst_blank", 104, 50, 0);
    for (int i = 0; i < NUM; i++) wr(i, i);
    wr(3, 15);
    sweep(50, 50, 140, 175);
    pin("blank_e3", 152, 50, 0);
    pin("e4_drawn", 172, 50, 1);

    // Blink
    bus.iBlinkEn = 1'b1;
    pin("blink_t0", 104, 50, 1);
    for (int i = 0; i < 31; i++) begin
      bus.iVGA_X = 11'($urandom_range(96, 240));
      tick();
    end
    pin("blink_t31", 104, 50, 1);
    tick();
    pin("blink_t32", 104, 50, 0);
    for (int i = 0; i < 31; i++) begin
      bus.iVGA_X = 11'($urandom_range(96, 240));
      tick();
    end
    pin("blink_t63", 104, 50, 0);
    tick();
    pin("blink_t64", 104, 50, 1);
    for (int i = 0; i < 32; i++) tick();
    bus.iBlinkEn = 1'b0;
    pin("blink_off", 104, 50, 1);
    bus.iBlinkEn = 1'b1;
    pin("blink_on_hid", 104, 50, 0);
    bus.iBlinkEn = 1'b0;

    // Clipping near the right screen edge
    setpos(2040, 0, 0);
    sweep(0, 1, 2034, 2047);
    sweep(0, 1, 0, 12);
    pin("clip_in", 2044, 0, 1);
    pin("clip_nowrap", 2, 0, 0);

    // Same-cycle write and read of entry 0
    setpos(100, 50, 0);
    bus.iVGA_Y  = 11'd50;
    bus.iVGA_X  = 11'd102;
    bus.iWrEn   = 1'b1;
    bus.iWrAddr = 3'd0;
    bus.iWrData = 4'd7;
    step();
    bus.iVGA_X = 11'd103;
    step();
    chk("coll_old", int'(bus.oDrawText), 0);
    bus.iVGA_X = 11'd104;
    step();
    chk("coll_new", int'(bus.oDrawText), 1);

    // Asynchronous reset during an active pixel
    step();
    step();
    chk("pre_reset", int'(bus.oDrawText), 1);
    #1 rst_n = 1'b0;
    #1 chk("async_drop", int'(bus.oDrawText), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("post_rel_1", int'(bus.oDrawText), 0);
    step();
    chk("post_rel_2", int'(bus.oDrawText), 0);
    pin("post_rel_blank", 104, 50, 0);
    sweep(50, 51, 96, 232);
    wr(0, 7);
    pin("rewrite", 104, 50, 1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0)
        setpos($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        bus.iWrEn   = 1'b1;
        bus.iWrAddr = 3'($urandom_range(0, 7));
        bus.iWrData = 4'($urandom_range(0, 15));
      end
      bus.iFrameTick = ($urandom_range(0, 3) == 0);
      bus.iEnable    = ($urandom_range(0, 7) != 0);
      bus.iBlinkEn   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.iVGA_X = 11'($urandom_range(0, 2047));
        bus.iVGA_Y = 11'($urandom_range(0, 2047));
      end else begin
        bus.iVGA_X = 11'(int'(bus.iPosX) + $urandom_range(0, 1100) - 4);
        bus.iVGA_Y = 11'(int'(bus.iPosY) + $urandom_range(0, 135) - 2);
      end
      step();
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/text_string_renderer.md
Name: text_string_renderer

Overview:
- Parametrised successor to the single-glyph letter/digit drawers.
- Renders a string of NUM_CHARS glyph codes, held in an internal writable character buffer, at a screen position with integer power-of-two scaling and optional blinking.
- Sits between the game-state logic (score, labels, "GAME OVER") and the VGA pixel mux.
- Produces one registered draw bit per pixel clock with a fixed pipeline latency.

Parameters:
NUM_CHARS, 8, characters in the string buffer (power of 2)
CODE_W, 4, glyph code width; ROM holds 2**CODE_W glyphs
GLYPH_W, 16, glyph width in pixels (power of 2)
GLYPH_H, 16, glyph height in pixels (power of 2)
BLANK_CODE, 15, code rendered as empty without a ROM lookup
BLINK_FRAMES, 32, frames per blink half-period

Ports:
iClk  in  1  pixel clock
iRst_n  in  1  asynchronous active-low reset
iPosX  in  11  left edge of string
iPosY  in  11  top edge of string
iVGA_X  in  11  current VGA column
iVGA_Y  in  11  current VGA row
iScale  in  2  scale shift s: pixel size 1,2,4,8
iEnable  in  1  draw enable (0 forces output low)
iBlinkEn  in  1  enable blink gating
iFrameTick  in  1  one-cycle pulse once per frame
iWrEn  in  1  character buffer write strobe
iWrAddr  in  clog2(NUM_CHARS)  buffer index
iWrData  in  CODE_W  glyph code
oDrawText  out  1  registered pixel-on

Behaviour:
- Reset (async assert):
  - oDrawText=0; all pipeline registers 0.
  - All buffer entries = BLANK_CODE; blink counter=0; blink phase=0.
  - After release, output stays 0 until valid pipeline data arrives, 2 cycles later.
- Geometry, stage 0 (combinational on cycle N inputs):
  - hit requires iVGA_X>=iPosX and iVGA_Y>=iPosY, compared as unsigned 11-bit. No modulo wrap: strings near 2047 clip.
  - relX=iVGA_X-iPosX, relY=iVGA_Y-iPosY, both 11-bit. Also requires relX < NUM_CHARS*GLYPH_W<<s and relY < GLYPH_H<<s.
  - Scaled coords: sx=relX>>s, sy=relY>>s. charIdx=sx/GLYPH_W; col=sx%GLYPH_W; row=sy%GLYPH_H.
  - ROM address = code*GLYPH_H+row, where code=buffer[charIdx].
- Pipeline:
  - End of cycle N: ROM registers address; col, hit, blankFlag (code==BLANK_CODE) are delayed one stage.
  - Cycle N+1: ROM q valid.
  - End of cycle N+1: oDrawText <= hit & iEnable & ~blankFlag & ~(iBlinkEn & phase) & q[GLYPH_W-1-col]. MSB is the leftmost pixel.
  - Latency: exactly 2 clocks from VGA coordinate to oDrawText. Throughput: 1 pixel/clock. No stalls.
  - iEnable, iBlinkEn and phase are sampled in stage 1.
- Buffer writes:
  - On iWrEn, buffer[iWrAddr]<=iWrData at the clock edge.
  - A write in the same cycle as a stage-0 read of the same entry: the read returns the old code; the new code applies from the next cycle.
  - iWrAddr>=NUM_CHARS is unreachable by width; no error path.
- Blink:
  - Counter increments on iFrameTick.
  - On the tick where counter==BLINK_FRAMES-1: counter<=0 and phase toggles.
  - Counter runs regardless of iBlinkEn. Phase=1 means hidden.
- Scale changes mid-frame take effect on the next pixel; no glitch filtering.
- iPosX/iPosY are used combinationally; callers change them only during blanking.

Decomposition:
- Shared package holds:
  - VGA coordinate width (11)
  - glyph ROM geometry constants (GLYPH_W, GLYPH_H, CODE_W)
  - BLANK_CODE
  - glyph code constants for digits and letters (0-9 digits, then letters)
- Sub-module glyph_rom: synchronous single-port ROM, 2**CODE_W*GLYPH_H words of GLYPH_W bits, registered address, 1-cycle read latency, MegaWizard-generated from a .mif.

Test Plan:
1. Basic draw:
   - Reset; write codes 0..7 to entries 0..7; s=0, pos (100,50); sweep VGA_X 100..227 on row 50.
   - oDrawText matches each glyph's row-0 bits, delayed 2 clocks.
   - Pixels 99 and 228 give 0.
2. Scaling:
   - s=2 with code 1 at entry 0.
   - Pixels (100..103,50..53) all equal glyph bit [15] of row 0.
   - Extent reaches X=100+8*64-1=611; X=612 gives 0.
3. Blank and reset:
   - After reset, no writes: whole string region yields 0.
   - Write BLANK_CODE to entry 3 after other writes: X 148..163 at s=0 stays 0.
4. Blink:
   - BLINK_FRAMES=32, iBlinkEn=1.
   - Ticks 0..31: drawn. After 32nd tick: 0 for 32 ticks. Then drawn again.
   - iBlinkEn=0: always drawn.
5. Clip and write collision:
   - pos (2040,0): only X 2040..2047 can draw; X 0..7 gives 0 (no wrap).
   - Same-cycle write/read of entry 0 shows old glyph on that pixel, new glyph next pixel.
6. Async reset mid-line:
   - Assert iRst_n=0 during an active pixel: oDrawText drops to 0 immediately without a clock.
   - After release: 0 for 2 clocks, then the string region reads as blank until rewritten.
